demux2_stream: RTL and testbench

DEMUX2_STREAM -- requirements
Module: demux2_stream

---
 rtl/demux2_pkg.sv | 18 +
 rtl/demux2_lane.sv | 81 ++++++++
 rtl/demux2_stream.sv | 89 ++++++++
 tb/tb_demux2_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux2_pkg.sv
// Shared constants and types for the two-lane stream demultiplexer.
// Optional feature macro used by the top level: DEMUX2_STREAM_CNT_EN
// (adds per-lane delivered-word counters cnt0/cnt1).
package demux2_pkg;

  localparam int DATA_W_DEF = 8;   // default stream data width
  localparam int CNT_W      = 16;  // delivered-word counter width
  localparam int LANE_DEPTH = 2;   // entries per lane FIFO

  // Lane occupancy doubles as the lane's state; it is exported for
  // observation and for the upstream ready decision.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'(LANE_DEPTH)
  } occ_e;

endpackage

// File: rtl/demux2_lane.sv
// One lane of demux2_stream: a 2-entry FIFO with registered head.
// Handshake: a word moves on a rising edge only when its valid and ready
// are both high in that cycle; valid never depends on ready.
// push_i is ignored while full, pop_i is ignored while empty.
module demux2_lane
  import demux2_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       occ_o
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (occ_q != OCC_FULL);
  assign pop_ok  = pop_i  && (occ_q != OCC_EMPTY);

  // Next-state: the head register is always the oldest word; a pop at
  // occupancy 2 promotes the tail, a push+pop at occupancy 1 replaces the head.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (occ_q == OCC_EMPTY) begin
          head_d = push_data_i;
          occ_d  = OCC_ONE;
        end else begin
          tail_d = push_data_i;
          occ_d  = OCC_FULL;
        end
      end
      2'b01: begin
        if (occ_q == OCC_FULL) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end else begin
          occ_d  = OCC_EMPTY;
        end
      end
      2'b11: begin
        // push_ok excludes FULL and pop_ok excludes EMPTY, so occupancy is 1.
        head_d = push_data_i;
        occ_d  = OCC_ONE;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Lane registers; reset discards any stored words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign valid_o = (occ_q != OCC_EMPTY);
  assign head_o  = head_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/demux2_stream.sv
// Two-lane stream demultiplexer: each upstream word is steered by in_sel
// into an independent 2-entry lane FIFO. Per-lane order is preserved; the
// lanes are not ordered against each other.
// Handshake: a transfer happens on a rising edge when valid && ready; valid
// and data are held by the source until accepted; outNvalid/outN_data come
// from registers only.
// Optional macro DEMUX2_STREAM_CNT_EN adds 16-bit wrapping per-lane
// delivered-word counters on ports cnt0/cnt1.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready
`ifdef DEMUX2_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic [1:0] occ0;
  logic [1:0] occ1;
  logic       push0;
  logic       push1;
  logic       pop0;
  logic       pop1;

  // Ready depends only on registered occupancy of the selected lane, so
  // there is no same-cycle path from outN_ready to in_ready.
  assign in_ready = in_sel ? (occ1 != OCC_FULL) : (occ0 != OCC_FULL);
  assign push0    = in_valid && in_ready && !in_sel;
  assign push1    = in_valid && in_ready &&  in_sel;
  assign pop0     = out0_valid && out0_ready;
  assign pop1     = out1_valid && out1_ready;

  demux2_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk         (clk),
    .rst         (reset),
    .push_i      (push0),
    .push_data_i (in_data),
    .pop_i       (pop0),
    .valid_o     (out0_valid),
    .head_o      (out0_data),
    .occ_o       (occ0)
  );

  demux2_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk         (clk),
    .rst         (reset),
    .push_i      (push1),
    .push_data_i (in_data),
    .pop_i       (pop1),
    .valid_o     (out1_valid),
    .head_o      (out1_data),
    .occ_o       (occ1)
  );

`ifdef DEMUX2_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Count delivered words per lane; natural wrap at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (pop0) cnt0_q <= cnt0_q + 1'b1;
      if (pop1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: per-lane queues model the expected stream
// contents; directed scenarios followed by randomized traffic.
module tb_demux2_stream;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_ready;
  logic         out0_valid;
  logic [W-1:0] out0_data;
  logic         out0_ready;
  logic         out1_valid;
  logic [W-1:0] out1_data;
  logic         out1_ready;
`ifdef DEMUX2_STREAM_CNT_EN
  logic [15:0]  cnt0;
  logic [15:0]  cnt1;
`endif

  always #5 clk = ~clk;

  demux2_stream #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready)
`ifdef DEMUX2_STREAM_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  int unsigned  exp_cnt0;
  int unsigned  exp_cnt1;
  int unsigned  n_pushed;
  int unsigned  n_popped;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp0_q.delete();
    exp1_q.delete();
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    n_pushed = 0;
    n_popped = 0;
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, check, advance one clock.
  task automatic drive_cycle(input logic iv, input logic [W-1:0] d,
                             input logic s, input logic r0, input logic r1);
    logic exp_rdy;
    logic do_pop0;
    logic do_pop1;
    logic do_push;
    in_valid   = iv;
    in_data    = d;
    in_sel     = s;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    exp_rdy = s ? (exp1_q.size() < 2) : (exp0_q.size() < 2);
    check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check_val("out0_valid", {31'd0, out0_valid}, {31'd0, exp0_q.size() != 0});
    check_val("out1_valid", {31'd0, out1_valid}, {31'd0, exp1_q.size() != 0});
    if (exp0_q.size() != 0) check_val("out0_data", {24'd0, out0_data}, {24'd0, exp0_q[0]});
    if (exp1_q.size() != 0) check_val("out1_data", {24'd0, out1_data}, {24'd0, exp1_q[0]});
`ifdef DEMUX2_STREAM_CNT_EN
    check_val("cnt0", {16'd0, cnt0}, exp_cnt0);
    check_val("cnt1", {16'd0, cnt1}, exp_cnt1);
`endif
    do_pop0 = r0 && (exp0_q.size() != 0);
    do_pop1 = r1 && (exp1_q.size() != 0);
    do_push = iv && exp_rdy;
    @(posedge clk);
    if (do_pop0) begin
      void'(exp0_q.pop_front());
      exp_cnt0 = (exp_cnt0 + 1) % 65536;
      n_popped++;
    end
    if (do_pop1) begin
      void'(exp1_q.pop_front());
      exp_cnt1 = (exp_cnt1 + 1) % 65536;
      n_popped++;
    end
    if (do_push) begin
      if (s) exp1_q.push_back(d);
      else   exp0_q.push_back(d);
      n_pushed++;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    model_clear();
    apply_reset();

    // Reset state
    #1;
    check_val("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check_val("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check_val("rst_out0_data", {24'd0, out0_data}, 32'd0);
    check_val("rst_out1_data", {24'd0, out1_data}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single word to lane 0, one-cycle latency
    drive_cycle(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    check_val("a5_valid0", {31'd0, out0_valid}, 32'd1);
    check_val("a5_data0", {24'd0, out0_data}, 32'hA5);
    check_val("a5_valid1", {31'd0, out1_valid}, 32'd0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_val("a5_drained", {31'd0, out0_valid}, 32'd0);

    // Lane 1 backpressure; lane 0 still ready
    drive_cycle(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    in_sel   = 1'b1;
    #1 check_val("bp_ready_sel1", {31'd0, in_ready}, 32'd0);
    in_sel   = 1'b0;
    #1 check_val("bp_ready_sel0", {31'd0, in_ready}, 32'd1);
    drive_cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);  // refused, must not land
    check_val("bp_first", {24'd0, out1_data}, 32'h11);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("bp_second", {24'd0, out1_data}, 32'h22);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("bp_empty", {31'd0, out1_valid}, 32'd0);

    // Simultaneous push and pop at occupancy 1
    drive_cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    check_val("pp_valid", {31'd0, out0_valid}, 32'd1);
    check_val("pp_data", {24'd0, out0_data}, 32'h33);
    in_sel = 1'b0;
    #1 check_val("pp_not_full", {31'd0, in_ready}, 32'd1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_val("pp_occ_one", {31'd0, out0_valid}, 32'd0);

    // Alternating lanes, then one lane at full rate
    for (int i = 0; i < 32; i++)
      drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'(i % 2), 1'b1, 1'b1);
    for (int i = 0; i < 16; i++)
      drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b1);
    drain();
    check_val("rate_no_loss", n_popped, n_pushed);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      drive_cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0));
    drain();
    check_val("rand_no_loss", n_popped, n_pushed);

    // Asynchronous reset with both lanes full
    drive_cycle(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hD2, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("async_valid0", {31'd0, out0_valid}, 32'd0);
    check_val("async_valid1", {31'd0, out1_valid}, 32'd0);
    check_val("async_data0", {24'd0, out0_data}, 32'd0);
    check_val("async_data1", {24'd0, out1_data}, 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive_cycle(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);  // first edge after release
    check_val("post_rst_push", {31'd0, out1_valid}, 32'd1);
    check_val("post_rst_data", {24'd0, out1_data}, 32'h5A);
    check_val("post_rst_lane0", {31'd0, out0_valid}, 32'd0);
    drain();

`ifdef DEMUX2_STREAM_CNT_EN
    // Counter wrap after 65536 lane-0 pops
    apply_reset();
    for (int i = 0; i < 65536; i++)
      drive_cycle(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    check_val("cnt0_ffff", {16'd0, cnt0}, 32'hFFFF);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #1;
    check_val("cnt0_wrap", {16'd0, cnt0}, 32'h0000);
    check_val("cnt1_hold", {16'd0, cnt1}, 32'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
